// File: rtl/shared_pkg.sv
// Shared AXI write-side types: bus widths, burst/response encodings and the write FSM states.
package shared_pkg;

  localparam int unsigned AxiAddrWidth = 16;
  localparam int unsigned AxiDataWidth = 32;
  localparam int unsigned AxiStrbWidth = AxiDataWidth / 8;

  typedef logic [AxiAddrWidth-1:0] addr_t;
  typedef logic [AxiDataWidth-1:0] data_t;
  typedef logic [AxiStrbWidth-1:0] strb_t;
  typedef logic [7:0]              len_t;
  typedef logic [2:0]              size_t;

  typedef enum logic [1:0] {
    BurstFixed = 2'b00,
    BurstIncr  = 2'b01,
    BurstWrap  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespExokay = 2'b01,
    RespSlverr = 2'b10,
    RespDecerr = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StResp
  } wr_state_e;

  // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(len_t len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI burst next-address generator with an illegal-burst flag.
// Shared by the write slave and usable by a read-side slave.
module axi_burst_addr_gen
  import shared_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  len_t                  len,
  input  size_t                 size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  illegal
);

  localparam size_t MaxSize = size_t'($clog2(DATA_WIDTH / 8));

  logic [ADDR_WIDTH-1:0] bytes;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  always_comb begin
    bytes     = ADDR_WIDTH'(1) << size;
    incr_addr = addr + bytes;
    // (len+1)*bytes is a power of two for every legal WRAP, so this is a low-bit mask.
    wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);

    illegal = (size > MaxSize) || (burst == 2'b11) ||
              ((burst == BurstWrap) && !wrap_len_ok(len));

    case (burst)
      BurstFixed: next_addr = addr;
      BurstIncr:  next_addr = incr_addr;
      BurstWrap:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:    next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_slave_wr_mem.sv
// AXI4 write-channel slave (AW/W/B) backed by a word-addressed memory,
// with a registered debug read port into the memory.
module axi_slave_wr_mem
  import shared_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned MEM_DEPTH  = 1024
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [ADDR_WIDTH-1:0]        awaddr,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [7:0]                   awlen,
  input  logic [2:0]                   awsize,
  input  logic [1:0]                   awburst,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [DATA_WIDTH/8-1:0]      wstrb,
  input  logic                         wvalid,
  output logic                         wready,
  input  logic                         wlast,
  output logic [1:0]                   bresp,
  output logic                         bvalid,
  input  logic                         bready,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]        dbg_rdata
);

  localparam int unsigned StrbWidth = DATA_WIDTH / 8;
  localparam int unsigned ByteShift = $clog2(StrbWidth);
  localparam int unsigned IdxWidth  = $clog2(MEM_DEPTH);
  localparam int unsigned CmpWidth  = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DepthLimit = CmpWidth'(MEM_DEPTH);

  wr_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  len_t                  len_q, len_d;
  size_t                 size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  len_t                  cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  illegal_q, illegal_d;

  logic       awready_q, awready_d;
  logic       wready_q, wready_d;
  logic       bvalid_q, bvalid_d;
  logic [1:0] bresp_q, bresp_d;

  logic [ADDR_WIDTH-1:0] ag_addr;
  logic [ADDR_WIDTH-1:0] ag_next;
  len_t                  ag_len;
  size_t                 ag_size;
  logic [1:0]            ag_burst;
  logic                  ag_illegal;

  logic                  aw_hs, w_hs, b_hs;
  logic                  last_beat;
  logic                  in_range;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] word_idx;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] dbg_rdata_q;

  assign aw_hs     = awvalid & awready_q;
  assign w_hs      = wvalid & wready_q;
  assign b_hs      = bvalid_q & bready;
  assign last_beat = (cnt_q == len_q);
  assign word_idx  = addr_q >> ByteShift;
  assign in_range  = ({1'b0, word_idx} < DepthLimit);

  // In IDLE the generator checks the incoming AW request; afterwards it steps the latched burst.
  always_comb begin
    if (state_q == StIdle) begin
      ag_addr  = awaddr;
      ag_len   = awlen;
      ag_size  = awsize;
      ag_burst = awburst;
    end else begin
      ag_addr  = addr_q;
      ag_len   = len_q;
      ag_size  = size_q;
      ag_burst = burst_q;
    end
  end

  axi_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_addr_gen (
    .addr      (ag_addr),
    .len       (ag_len),
    .size      (ag_size),
    .burst     (ag_burst),
    .next_addr (ag_next),
    .illegal   (ag_illegal)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    illegal_d = illegal_q;
    mem_we    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (aw_hs) begin
          addr_d    = awaddr;
          len_d     = awlen;
          size_d    = awsize;
          burst_d   = awburst;
          cnt_d     = '0;
          err_d     = ag_illegal;
          illegal_d = ag_illegal;
          state_d   = StData;
        end
      end
      StData: begin
        if (w_hs) begin
          addr_d = ag_next;
          cnt_d  = cnt_q + 8'd1;
          mem_we = !illegal_q && in_range && !areset;
          if (!in_range || (wlast != last_beat)) begin
            err_d = 1'b1;
          end
          // The burst length comes from awlen alone; wlast only feeds the error flag.
          if (last_beat) begin
            state_d = StResp;
          end
        end
      end
      StResp: begin
        if (b_hs) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    awready_d = (state_d == StIdle);
    wready_d  = (state_d == StData);
    bvalid_d  = (state_d == StResp);
    bresp_d   = ((state_d == StResp) && err_d) ? RespSlverr : RespOkay;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      illegal_q <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      illegal_q <= illegal_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Memory has no reset; contents survive areset.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < StrbWidth; b++) begin
        if (wstrb[b]) begin
          mem[word_idx[IdxWidth-1:0]][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      dbg_rdata_q <= '0;
    end else begin
      dbg_rdata_q <= mem[dbg_addr];
    end
  end

  assign awready   = awready_q;
  assign wready    = wready_q;
  assign bvalid    = bvalid_q;
  assign bresp     = bresp_q;
  assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_axi_slave_wr_mem.sv
// Randomised self-checking bench for axi_slave_wr_mem against a burst-level memory model.
module tb_axi_slave_wr_mem;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 16;
  localparam int unsigned DEPTH = 1024;

  logic          aclk = 1'b0;
  logic          areset;
  logic [AW-1:0] awaddr;
  logic          awvalid;
  logic          awready;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic          wvalid;
  logic          wready;
  logic          wlast;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic [9:0]    dbg_addr;
  logic [DW-1:0] dbg_rdata;

  always #5 aclk = ~aclk;

  axi_slave_wr_mem #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MEM_DEPTH  (DEPTH)
  ) dut (
    .aclk      (aclk),
    .areset    (areset),
    .awaddr    (awaddr),
    .awvalid   (awvalid),
    .awready   (awready),
    .awlen     (awlen),
    .awsize    (awsize),
    .awburst   (awburst),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wvalid    (wvalid),
    .wready    (wready),
    .wlast     (wlast),
    .bresp     (bresp),
    .bvalid    (bvalid),
    .bready    (bready),
    .dbg_addr  (dbg_addr),
    .dbg_rdata (dbg_rdata)
  );

  logic [31:0] ref_mem   [DEPTH];
  logic [31:0] beat_data [256];
  logic [3:0]  beat_strb [256];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Byte address of beat i, straight from the burst definitions.
  function automatic int unsigned beat_addr(int unsigned start, int unsigned len,
                                            int unsigned size, int unsigned burst,
                                            int unsigned i);
    int unsigned bytes;
    int unsigned wrap;
    int unsigned base;
    bytes = 1 << size;
    wrap  = (len + 1) * bytes;
    base  = start - (start % wrap);
    case (burst)
      0:       return start;
      1:       return (start + i * bytes) % 65536;
      default: return base + ((start % wrap) + i * bytes) % wrap;
    endcase
  endfunction

  function automatic bit burst_illegal(int unsigned len, int unsigned size, int unsigned burst);
    return (size > 2) || (burst == 3) ||
           ((burst == 2) && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  task automatic read_word(input int unsigned w, output logic [31:0] d);
    logic [31:0] wv;
    wv       = w;
    dbg_addr = wv[9:0];
    step();
    d = dbg_rdata;
  endtask

  task automatic check_mem(input int unsigned lo, input int unsigned hi);
    logic [31:0] d;
    for (int unsigned w = lo; w <= hi; w++) begin
      read_word(w, d);
      check_eq($sformatf("mem[%0d]", w), d, ref_mem[w]);
    end
  endtask

  // Drives one burst from beat_data/beat_strb; abort_after >= 0 pulses areset after that beat.
  task automatic run_burst(input int unsigned start, input int unsigned len,
                           input int unsigned size, input int unsigned burst,
                           input int unsigned wlast_at, input int unsigned b_delay,
                           input bit b_early, input int abort_after);
    bit          ill;
    bit          exp_err;
    bit          done;
    int unsigned a;
    int unsigned w;
    logic [31:0] sv;
    logic [1:0]  exp_resp;
    ill     = burst_illegal(len, size, burst);
    exp_err = ill || (wlast_at != len);

    sv      = start;
    awaddr  = sv[15:0];
    sv      = len;
    awlen   = sv[7:0];
    sv      = size;
    awsize  = sv[2:0];
    sv      = burst;
    awburst = sv[1:0];
    awvalid = 1'b1;
    done    = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      if (awready) done = 1'b1;
      step();
    end
    awvalid = 1'b0;
    check_eq("aw_handshake", 32'(done), 1);
    if (!done) return;
    check_eq("awready_in_data", 32'(awready), 0);
    check_eq("wready_in_data", 32'(wready), 1);
    if (b_early) bready = 1'b1;

    for (int unsigned i = 0; i <= len; i++) begin
      wvalid = 1'b0;
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) step();
      wdata  = beat_data[i];
      wstrb  = beat_strb[i];
      wlast  = (i == wlast_at);
      wvalid = 1'b1;
      done   = 1'b0;
      for (int t = 0; t < 100 && !done; t++) begin
        if (wready) done = 1'b1;
        step();
      end
      wvalid = 1'b0;
      wlast  = 1'b0;
      if (!done) begin
        check_eq("w_handshake", 32'(done), 1);
        return;
      end
      if (!ill) begin
        a = beat_addr(start, len, size, burst, i);
        w = a >> 2;
        if (w < DEPTH) begin
          for (int b = 0; b < 4; b++) begin
            if (beat_strb[i][b]) ref_mem[w][8*b +: 8] = beat_data[i][8*b +: 8];
          end
        end else begin
          exp_err = 1'b1;
        end
      end
      if (abort_after >= 0 && int'(i) == abort_after) begin
        areset = 1'b1;
        step();
        check_eq("rst_awready", 32'(awready), 0);
        check_eq("rst_wready", 32'(wready), 0);
        check_eq("rst_bvalid", 32'(bvalid), 0);
        check_eq("rst_bresp", 32'(bresp), 0);
        areset = 1'b0;
        step();
        check_eq("post_rst_awready", 32'(awready), 1);
        check_eq("post_rst_wready", 32'(wready), 0);
        check_eq("post_rst_bvalid", 32'(bvalid), 0);
        return;
      end
    end

    exp_resp = exp_err ? 2'b10 : 2'b00;
    check_eq("bvalid_after_last_w", 32'(bvalid), 1);
    check_eq("wready_in_resp", 32'(wready), 0);
    check_eq("bresp", 32'(bresp), 32'(exp_resp));
    if (b_early) begin
      step();
      bready = 1'b0;
    end else begin
      for (int unsigned d = 0; d < b_delay; d++) begin
        step();
        check_eq("bvalid_hold", 32'(bvalid), 1);
        check_eq("bresp_hold", 32'(bresp), 32'(exp_resp));
        check_eq("awready_during_b", 32'(awready), 0);
      end
      bready = 1'b1;
      step();
      bready = 1'b0;
    end
    check_eq("bvalid_cleared", 32'(bvalid), 0);
    check_eq("awready_after_b", 32'(awready), 1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int unsigned r, burst, len, size, start, wlast_at;

    areset   = 1'b1;
    awaddr   = '0;
    awvalid  = 1'b0;
    awlen    = '0;
    awsize   = '0;
    awburst  = '0;
    wdata    = '0;
    wstrb    = '0;
    wvalid   = 1'b0;
    wlast    = 1'b0;
    bready   = 1'b0;
    dbg_addr = '0;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;

    repeat (3) step();
    check_eq("reset_awready", 32'(awready), 0);
    check_eq("reset_wready", 32'(wready), 0);
    check_eq("reset_bvalid", 32'(bvalid), 0);
    check_eq("reset_bresp", 32'(bresp), 0);
    check_eq("reset_dbg_rdata", dbg_rdata, 0);
    areset = 1'b0;
    step();
    check_eq("awready_after_reset", 32'(awready), 1);

    // Zero the memory so the model starts from known contents.
    for (int i = 0; i < 256; i++) begin
      beat_data[i] = '0;
      beat_strb[i] = 4'hF;
    end
    for (int unsigned k = 0; k < 4; k++) run_burst(k * 1024, 255, 2, 1, 255, 0, 1'b0, -1);

    for (int i = 0; i < 4; i++) beat_data[i] = 32'hA0 + i;
    run_burst(16'h0010, 3, 2, 1, 3, 0, 1'b0, -1);
    for (int unsigned i = 0; i < 4; i++) begin
      read_word(4 + i, d);
      check_eq("incr_word", d, 32'hA0 + i);
    end

    for (int i = 0; i < 4; i++) beat_data[i] = 32'hB0 + i;
    run_burst(16'h0018, 3, 2, 2, 3, 0, 1'b0, -1);
    read_word(6, d); check_eq("wrap_w6", d, 32'hB0);
    read_word(7, d); check_eq("wrap_w7", d, 32'hB1);
    read_word(4, d); check_eq("wrap_w4", d, 32'hB2);
    read_word(5, d); check_eq("wrap_w5", d, 32'hB3);

    beat_data[0] = 32'h11111111; beat_strb[0] = 4'h1;
    beat_data[1] = 32'h22222222; beat_strb[1] = 4'h2;
    beat_data[2] = 32'h44444444; beat_strb[2] = 4'h4;
    run_burst(16'h0020, 2, 2, 0, 2, 0, 1'b0, -1);
    read_word(8, d); check_eq("fixed_w8", d, 32'h00442211);

    // wlast on beat 0 of a 2-beat burst; zero strobes keep memory untouched.
    for (int i = 0; i < 4; i++) begin
      beat_data[i] = $urandom;
      beat_strb[i] = 4'h0;
    end
    run_burst(16'h0030, 1, 2, 1, 0, 0, 1'b0, -1);
    check_mem(12, 13);

    for (int i = 0; i < 4; i++) beat_strb[i] = 4'hF;
    run_burst(16'h0040, 2, 2, 2, 2, 0, 1'b0, -1);
    check_mem(16, 19);
    run_burst(16'h0050, 1, 3, 1, 1, 0, 1'b0, -1);
    check_mem(20, 23);
    run_burst(DEPTH * 4, 0, 2, 1, 0, 0, 1'b0, -1);

    run_burst(16'h0060, 1, 2, 1, 1, 5, 1'b0, -1);
    check_mem(24, 25);
    run_burst(16'h0068, 0, 2, 1, 0, 0, 1'b1, -1);
    check_mem(26, 26);

    for (int i = 0; i < 4; i++) beat_data[i] = 32'hC0 + i;
    run_burst(16'h0080, 3, 2, 1, 3, 0, 1'b0, 1);
    read_word(32, d); check_eq("abort_w32", d, 32'hC0);
    read_word(33, d); check_eq("abort_w33", d, 32'hC1);
    check_mem(32, 35);

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      burst = (r < 4) ? 1 : (r < 7) ? 2 : (r < 9) ? 0 : 3;
      if (burst == 2 && $urandom_range(0, 4) != 0) len = (4 << $urandom_range(0, 2)) - 1;
      else if (burst == 2 && $urandom_range(0, 1) == 0) len = 1;
      else len = $urandom_range(0, 15);
      size  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      start = ($urandom_range(0, 9) == 0) ? $urandom_range(16'hF000, 16'hFFFF)
                                          : $urandom_range(0, DEPTH * 4 - 1);
      wlast_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len + 1) : len;
      for (int i = 0; i < 16; i++) begin
        beat_data[i] = $urandom;
        beat_strb[i] = 4'($urandom_range(0, 15));
      end
      run_burst(start, len, size, burst, wlast_at, $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0), -1);
    end

    check_mem(0, DEPTH - 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_slave_wr_mem.md
Name: axi_slave_wr_mem

Overview:
AXI4 write-side slave endpoint with word-addressed backing memory. It sits directly downstream of the AXI master driver on the AXI_if write channels (AW, W, B) and consumes every write burst the master issues. It supports FIXED, INCR and WRAP bursts, applies byte strobes, and returns one B response per burst. A registered debug read port lets the bench check memory contents without the AXI read channels.

Parameters:
DATA_WIDTH, 32, data bus width in bits (power of 2, >= 8)
ADDR_WIDTH, 16, byte address width
MEM_DEPTH, 1024, number of DATA_WIDTH words in memory

Ports:
aclk  in  1  clock; all logic on rising edge
areset  in  1  synchronous active-high reset
awaddr  in  ADDR_WIDTH  burst start byte address
awvalid  in  1  AW valid
awready  out  1  AW ready
awlen  in  8  beats minus 1
awsize  in  3  log2 bytes per beat
awburst  in  2  FIXED=00, INCR=01, WRAP=10
wdata  in  DATA_WIDTH  write data
wstrb  in  DATA_WIDTH/8  byte lane enables
wvalid  in  1  W valid
wready  out  1  W ready
wlast  in  1  last beat marker
bresp  out  2  OKAY=00, SLVERR=10
bvalid  out  1  B valid
bready  in  1  B ready
dbg_addr  in  $clog2(MEM_DEPTH)  debug word index
dbg_rdata  out  DATA_WIDTH  mem[dbg_addr], registered, 1-cycle latency

Behaviour:
- One clock, aclk. Reset is synchronous and active-high on areset.
- Reset values: awready=0, wready=0, bvalid=0, bresp=OKAY, dbg_rdata=0, FSM=IDLE. Memory contents are not cleared.
- awready rises in the first cycle after reset deasserts.
- FSM states: IDLE, DATA, RESP.
- IDLE: awready=1. On awvalid&awready, latch addr, len, size and burst. Clear the beat counter and the error flag. Go to DATA; awready=0 from the next cycle.
- DATA: wready=1. On each wvalid&wready:
  - write the enabled bytes to word addr>>log2(DATA_WIDTH/8);
  - advance the address;
  - increment the counter.
- On the handshake where counter==len, go to RESP; wready=0 from the next cycle.
- The burst ends on beat count only, never on wlast. wlast=1 with counter!=len, or wlast=0 with counter==len, sets the error flag.
- RESP: bvalid=1, bresp=SLVERR if the error flag is set, else OKAY. bvalid and bresp hold stable until bready. On bvalid&bready go to IDLE, so awready=1 on the following cycle. bready may already be high when bvalid rises; the handshake then completes that cycle.
- Next-address rules, with bytes=1<<size:
  - FIXED: unchanged.
  - INCR: addr+bytes, modulo 2^ADDR_WIDTH.
  - WRAP: wrap_bytes=(len+1)*bytes; base=addr & ~(wrap_bytes-1); next=base | ((addr+bytes) & (wrap_bytes-1)).
- Burst errors (error flag set at AW handshake, all beats still accepted, no memory writes for the whole burst):
  - size > log2(DATA_WIDTH/8);
  - WRAP with len not in {1,3,7,15};
  - burst=11.
- Beat errors: word index >= MEM_DEPTH drops that beat's write and sets the error flag. Other beats in the burst still write.
- Strobes are applied as given; lane selection for narrow beats is the master's responsibility.
- 4 KB boundary crossing is not checked.
- Debug port: dbg_rdata is mem[dbg_addr] sampled at the clock edge, read-before-write. A same-cycle write to the same word is visible one cycle later.
- areset asserted mid-burst or in RESP: IDLE on the next edge, outputs at reset values. Beats already written stay in memory; no B response is issued for the aborted burst.

Decomposition:
- shared_pkg holds addr_t, data_t, strb_t, len_t (8b), size_t (3b), burst_t enum (FIXED/INCR/WRAP), resp_t enum (OKAY/EXOKAY/SLVERR/DECERR), and the write FSM state enum wr_state_e.
- Sub-module axi_burst_addr_gen: combinational next-address from addr/len/size/burst, plus an illegal-burst flag. It is reusable by a future read-side slave.

Test Plan:
- INCR, awaddr=0x0010, len=3, size=2, data 0xA0..0xA3, wstrb=F -> words 4..7 = A0..A3; bresp=OKAY; bvalid exactly 1 cycle after last W handshake.
- WRAP, awaddr=0x0018, len=3, size=2 -> writes to words 6,7,4,5; bresp=OKAY.
- FIXED, awaddr=0x0020, len=2, wstrb 1,2,4, data 0x11111111/0x22222222/0x44444444 (word 8 preloaded 0) -> word 8 = 0x00442211.
- Protocol errors -> bresp=SLVERR, memory unchanged:
  - len=1 burst with wlast on beat 0;
  - WRAP len=2;
  - size=3.
- Range and reset: awaddr=MEM_DEPTH*4, len=0 -> no write, SLVERR. areset pulsed after beat 1 of a len=3 INCR -> next cycle awready=1, wready=0, bvalid=0; words from beats 0-1 retained.
- Backpressure: bready held 0 for 5 cycles -> bvalid and bresp stable; awready stays 0 until 1 cycle after the B handshake.
